pipelined_adder: RTL
====================

// Module: pipelined_adder
// PURPOSE
//   Parametrised, pipelined add/subtract unit with valid/ready flow control.
//   Splits the WIDTH-bit ripple carry into STAGES chunks, one chunk per cycle.
//   Carry is registered between stages, so cycle time is bounded by CHUNK bits of ripple.
//   Serves as the datapath ALU adder and the PC/branch-target adder where timing needs it.
// PARAMETERS
//   WIDTH   32  operand/result width; must be a multiple of STAGES
//   STAGES  4   pipeline depth = latency in cycles; 1..WIDTH; CHUNK = WIDTH/STAGES
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      unit accepts a beat this cycle
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   Cin        in   1      carry in; used only when Sub=0
//   Sub        in   1      1: A-B (A+~B+1); 0: A+B+Cin
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts result
//   Sum        out  WIDTH  result
//   Cout       out  1      carry out of MSB (for Sub=1: 1 means no borrow)
//   Ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
// - Handshake and stall
//   - Beat accepted when in_valid & in_ready.
//   - Beat delivered when out_valid & out_ready.
//   - advance = !out_valid | out_ready. All stage registers update only when advance=1.
//   - in_ready = advance; combinational from out_ready, no other comb path in->out.
//   - Stall freezes the whole pipe. Bubbles are not collapsed.
//   - Sum/Cout/Ovf hold stable while out_valid & !out_ready.
// - Datapath
//   - Stage 0 forms B' = Sub ? ~B : B and c0 = Sub ? 1 : Cin.
//   - Stage k (0..STAGES-1) adds chunk k of A and B' with the carry from stage k-1.
//   - Stage k registers: valid bit, completed low sum chunks 0..k, carry, and the
//     untouched upper A/B' chunks (k+1..STAGES-1), which are skewed forward.
//   - Final stage also registers Cout and Ovf.
// - Latency and throughput
//   - Exactly STAGES cycles from acceptance to out_valid when not stalled.
//   - Throughput is 1 beat/cycle.
//   - STAGES=1 gives a single registered ripple adder.
// - Arithmetic
//   - Modulo 2^WIDTH; no saturation.
//   - Ovf follows two's-complement rules for both add and sub.
// - Reset (rst_n=0, asynchronous)
//   - All valid bits, Sum, Cout and Ovf clear to 0 immediately.
//   - out_valid=0. in_ready=1 once in reset, since out_valid=0.
//   - In-flight beats are discarded. Reset mid-stream loses them silently.
//   - Operand/carry pipeline registers need no reset, but must never be observable
//     while their valid bit is 0.
// - Boundary conditions
//   - in_valid=0 while advancing inserts a bubble; that valid bit shifts as 0.
//   - Accept and deliver in the same cycle is legal and required when the pipe is full
//     and out_ready=1.
//   - out_ready is ignored when out_valid=0.
// STRUCTURE
//   - Package adder_pkg:
//     - localparam OP_ADD=1'b0, OP_SUB=1'b1.
//     - Function chunk_of(width, stages).
//     - Typedef for the stage record struct: valid, carry, partial sum, skewed operands.
//   - Sub-module chunk_adder #(CHUNK): combinational CHUNK-bit ripple built from per-bit
//     full-adder logic. Outputs sum, carry out, and carry into its MSB (for Ovf).
//     Instantiated STAGES times via generate.
//   - pipelined_adder holds only the stage registers and the stall/handshake logic.
// TESTING
//   1. Reset: assert rst_n=0 mid-stream with 3 beats in flight -> out_valid=0 at once;
//      after release no stale beat ever appears.
//   2. Carry across chunks (WIDTH=32, STAGES=4): A=32'h00FF_FFFF, B=1, Cin=0
//      -> Sum=32'h0100_0000, Cout=0, Ovf=0, exactly 4 cycles later.
//   3. Subtract and overflow: A=32'h8000_0000, B=1, Sub=1
//      -> Sum=32'h7FFF_FFFF, Cout=1, Ovf=1.
//      Then A=5, B=7, Sub=1 -> Sum=32'hFFFF_FFFE, Cout=0, Ovf=0.
//   4. Full add wrap: A=32'hFFFF_FFFF, B=0, Cin=1 -> Sum=0, Cout=1, Ovf=0.
//      Cin=1 with Sub=1 is ignored: A=3, B=3 -> Sum=0.
//   5. Back-pressure: stream 8 beats with out_ready toggling 1,0,0,1,...
//      -> results in order, none lost or duplicated, outputs stable while stalled,
//      in_ready=0 exactly when out_valid & !out_ready.
//   6. Random regression vs reference model (A+B+Cin or A-B) for WIDTH/STAGES in
//      {8/1, 8/8, 32/4, 64/2}, with random in_valid/out_ready -> zero mismatches.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and types for the pipelined add/subtract unit.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Control portion of a stage record; data fields are sized by the instantiating module.
    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } stage_ctl_t;

    function automatic int chunk_of(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB for overflow.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract unit with the carry chain cut into STAGES registered chunks.
// WIDTH must be a multiple of STAGES; the whole pipe stalls together on back-pressure.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int CHUNK = chunk_of(WIDTH, STAGES);

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t pipe [STAGES];
    stage_t nxt  [STAGES];
    logic   advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src;
        stage_t           n;
        logic [CHUNK-1:0] s;
        logic             co;
        logic             cm;

        if (k == 0) begin : g_head
            assign src.ctl.valid = in_valid;
            assign src.ctl.carry = (Sub == OP_SUB) ? 1'b1 : Cin;
            assign src.ctl.ovf   = 1'b0;
            assign src.sum       = '0;
            assign src.a         = A;
            assign src.b         = (Sub == OP_ADD) ? B : ~B;
        end else begin : g_body
            assign src = pipe[k-1];
        end

        chunk_adder #(.CHUNK(CHUNK)) u_chunk (
            .a    (src.a[k*CHUNK +: CHUNK]),
            .b    (src.b[k*CHUNK +: CHUNK]),
            .cin  (src.ctl.carry),
            .sum  (s),
            .cout (co),
            .cmsb (cm)
        );

        always_comb begin
            n                       = src;
            n.sum[k*CHUNK +: CHUNK] = s;
            n.ctl.carry             = co;
            n.ctl.ovf               = cm ^ co;
            // Bubbles leave the output stage as zeros so stale operands never show on Sum.
            if (k == STAGES - 1 && !src.ctl.valid) begin
                n.sum       = '0;
                n.ctl.carry = 1'b0;
                n.ctl.ovf   = 1'b0;
            end
        end

        assign nxt[k] = n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) pipe[k] <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) pipe[k] <= nxt[k];
        end
    end

    assign out_valid = pipe[STAGES-1].ctl.valid;
    assign Sum       = pipe[STAGES-1].sum;
    assign Cout      = pipe[STAGES-1].ctl.carry;
    assign Ovf       = pipe[STAGES-1].ctl.ovf;

endmodule
